// File: rtl/sparserdes_encoder.sv
// Sparse SerDes tree encoder: turns an occupancy mask into a pruned, depth-first
// binary-tree bitstream framed by an enable pulse, ready for the sparse decoder.
module sparserdes_encoder #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] mask_in,
  input  logic            mask_valid,
  output logic            mask_ready,
  output logic            enable,
  output logic            bitstream,
  output logic            bit_valid,
  output logic            last
);

  localparam int DEPTH = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GAP,
    EMIT_LO,
    EMIT_HI,
    DONE
  } state_t;

  state_t state, state_next;

  logic [SIZE-1:0]  mask_q;
  logic [DEPTH-1:0] level, prefix, pend;
  logic [DEPTH-1:0] level_next, prefix_next, pend_next;
  logic             lo_occ, hi_occ, has_next;

  // Subtree ORs of the current node's two halves, taken from the captured mask.
  always_comb begin : occupancy
    int              span;
    int              base;
    logic [SIZE-1:0] shifted;
    logic [SIZE-1:0] half_mask;
    span      = 1 << int'(level);
    base      = int'(prefix) << (int'(level) + 1);
    shifted   = mask_q >> base;
    half_mask = (SIZE'(1) << span) - SIZE'(1);
    lo_occ    = |(shifted & half_mask);
    hi_occ    = |((shifted >> span) & half_mask);
  end

  // Next node in pre-order: descend low-first, otherwise pop the deepest pending
  // high sibling; its prefix is the matching ancestor's prefix with the LSB set.
  always_comb begin : next_node
    level_next  = level;
    prefix_next = prefix;
    pend_next   = pend;
    has_next    = 1'b0;
    if (level != '0 && lo_occ) begin
      has_next    = 1'b1;
      level_next  = level - 1'b1;
      prefix_next = prefix << 1;
      if (hi_occ) pend_next[level - 1'b1] = 1'b1;
    end else if (level != '0 && hi_occ) begin
      has_next    = 1'b1;
      level_next  = level - 1'b1;
      prefix_next = (prefix << 1) | DEPTH'(1);
    end else begin
      for (int l = DEPTH - 1; l >= 0; l--) begin
        if (pend[l] && l >= int'(level)) begin
          has_next    = 1'b1;
          level_next  = DEPTH'(l);
          prefix_next = (prefix >> (l - int'(level))) | DEPTH'(1);
          pend_next   = pend & ~(DEPTH'(1) << l);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Node registers load the root on accept and advance after each high bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q <= '0;
      level  <= '0;
      prefix <= '0;
      pend   <= '0;
    end else if (state == IDLE && mask_valid) begin
      mask_q <= mask_in;
      level  <= DEPTH'(DEPTH - 1);
      prefix <= '0;
      pend   <= '0;
    end else if (state == EMIT_HI) begin
      level  <= level_next;
      prefix <= prefix_next;
      pend   <= pend_next;
    end
  end

  // DONE carries the final high bit, so the frame ends without a dead cycle.
  always_comb begin
    state_next = state;
    mask_ready = 1'b0;
    enable     = 1'b0;
    bitstream  = 1'b0;
    bit_valid  = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        mask_ready = 1'b1;
        if (mask_valid) state_next = START;
      end
      START: begin
        enable     = 1'b1;
        state_next = GAP;
      end
      GAP: state_next = EMIT_LO;
      EMIT_LO: begin
        bit_valid  = 1'b1;
        bitstream  = lo_occ;
        state_next = has_next ? EMIT_HI : DONE;
      end
      EMIT_HI: begin
        bit_valid  = 1'b1;
        bitstream  = hi_occ;
        state_next = EMIT_LO;
      end
      DONE: begin
        bit_valid  = 1'b1;
        bitstream  = hi_occ;
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sparserdes_encoder.sv
// Bench for sparserdes_encoder: directed SIZE=8 frames plus random SIZE=16
// frames decoded back into a mask by a bench-side tree decoder.
module tb_sparserdes_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mask_in;
  logic        mask_valid;
  logic        sel16;

  logic rdy8, en8, bs8, bv8, last8;
  logic rdy16, en16, bs16, bv16, last16;
  logic o_rdy, o_en, o_bs, o_bv, o_last;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_bits[$];
  bit rx_bits[$];

  always #5 clk = ~clk;

  sparserdes_encoder #(.SIZE(8)) u_enc8 (
    .clk        (clk),
    .reset      (reset),
    .mask_in    (mask_in[7:0]),
    .mask_valid (mask_valid && !sel16),
    .mask_ready (rdy8),
    .enable     (en8),
    .bitstream  (bs8),
    .bit_valid  (bv8),
    .last       (last8)
  );

  sparserdes_encoder #(.SIZE(16)) u_enc16 (
    .clk        (clk),
    .reset      (reset),
    .mask_in    (mask_in),
    .mask_valid (mask_valid && sel16),
    .mask_ready (rdy16),
    .enable     (en16),
    .bitstream  (bs16),
    .bit_valid  (bv16),
    .last       (last16)
  );

  assign o_rdy  = sel16 ? rdy16  : rdy8;
  assign o_en   = sel16 ? en16   : en8;
  assign o_bs   = sel16 ? bs16   : bs8;
  assign o_bv   = sel16 ? bv16   : bv8;
  assign o_last = sel16 ? last16 : last8;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pre-order with pruning equals: walk addresses, at each aligned start list the
  // nodes from the highest level down, keeping the root and every non-empty node.
  task automatic build_expected(input logic [15:0] m, input int size);
    int depth;
    int w;
    bit lo, hi;
    depth = $clog2(size);
    exp_bits.delete();
    for (int a = 0; a < size; a++) begin
      for (int l = depth - 1; l >= 0; l--) begin
        w = 1 << (l + 1);
        if (a % w == 0) begin
          lo = 1'b0;
          hi = 1'b0;
          for (int k = 0; k < w / 2; k++) begin
            lo = lo | m[a + k];
            hi = hi | m[a + w / 2 + k];
          end
          if (lo || hi || l == depth - 1) begin
            exp_bits.push_back(lo);
            exp_bits.push_back(hi);
          end
        end
      end
    end
  endtask

  task automatic decode_bits(input int size, output logic [15:0] m);
    int lv[$];
    int px[$];
    int idx;
    int l, p;
    bit lo, hi;
    m   = '0;
    idx = 0;
    lv.push_back($clog2(size) - 1);
    px.push_back(0);
    while (lv.size() > 0 && idx + 1 < rx_bits.size()) begin
      l = lv.pop_back();
      p = px.pop_back();
      lo = rx_bits[idx];
      hi = rx_bits[idx + 1];
      idx += 2;
      if (l == 0) begin
        m[2 * p]     = lo;
        m[2 * p + 1] = hi;
      end else begin
        if (hi) begin lv.push_back(l - 1); px.push_back(2 * p + 1); end
        if (lo) begin lv.push_back(l - 1); px.push_back(2 * p); end
      end
    end
  endtask

  // Offers one mask and checks the whole frame cycle by cycle; abort_bit >= 0
  // pulls reset during that bit index and checks the block went idle.
  task automatic applyStimulus(input logic [15:0] m, input bit use16, input bit hold,
                               input bit toggle, input int abort_bit);
    int n;
    sel16 = use16;
    n = 0;
    while (!o_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) begin
      checkOutput("ready_timeout", 32'(o_rdy), 32'd1);
      return;
    end
    mask_in    = m;
    mask_valid = 1'b1;
    build_expected(m, use16 ? 16 : 8);
    @(posedge clk);
    #1;
    if (!hold) mask_valid = 1'b0;
    if (toggle) mask_in = 16'($urandom);
    @(negedge clk);
    checkOutput("enable_t1", 32'(o_en), 32'd1);
    checkOutput("bit_valid_t1", 32'(o_bv), 32'd0);
    @(negedge clk);
    checkOutput("enable_t2", 32'(o_en), 32'd0);
    checkOutput("bit_valid_t2", 32'(o_bv), 32'd0);
    rx_bits.delete();
    for (int i = 0; i < exp_bits.size(); i++) begin
      @(negedge clk);
      checkOutput("bit_valid", 32'(o_bv), 32'd1);
      checkOutput("bitstream", 32'(o_bs), 32'(exp_bits[i]));
      checkOutput("last", 32'(o_last), 32'(i == exp_bits.size() - 1));
      rx_bits.push_back(o_bs);
      if (i == abort_bit) begin
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_enable", 32'(o_en), 32'd0);
        checkOutput("abort_bit_valid", 32'(o_bv), 32'd0);
        checkOutput("abort_bitstream", 32'(o_bs), 32'd0);
        checkOutput("abort_last", 32'(o_last), 32'd0);
        checkOutput("abort_ready", 32'(o_rdy), 32'd1);
        reset = 1'b1;
        return;
      end
    end
    @(negedge clk);
    checkOutput("ready_after", 32'(o_rdy), 32'd1);
    checkOutput("bit_valid_after", 32'(o_bv), 32'd0);
    checkOutput("last_after", 32'(o_last), 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] got;
    reset      = 1'b0;
    mask_in    = '0;
    mask_valid = 1'b0;
    sel16      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(o_rdy), 32'd1);
    checkOutput("reset_enable", 32'(o_en), 32'd0);
    checkOutput("reset_bit_valid", 32'(o_bv), 32'd0);
    checkOutput("reset_bitstream", 32'(o_bs), 32'd0);
    checkOutput("reset_last", 32'(o_last), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed SIZE=8 frames");
    applyStimulus(16'h01, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(16'h81, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(16'h00, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(16'hFF, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(16'h80, 1'b0, 1'b1, 1'b0, -1);
    applyStimulus(16'h01, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(16'hFF, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(16'hFF, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(16'h24, 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] random SIZE=16 loopback frames");
    for (int f = 0; f < 24; f++) begin
      m = 16'($urandom);
      if (f == 0) m = 16'h0000;
      if (f == 1) m = 16'hFFFF;
      if (f == 2) m = 16'h8000;
      if (f % 5 == 3) m = m & 16'($urandom) & 16'($urandom);
      applyStimulus(m, 1'b1, 1'b0, 1'b1, -1);
      decode_bits(16, got);
      checkOutput("loopback_mask", 32'(got), 32'(m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
